// File: rtl/ibex_dffram_arbiter_if.sv
// Request/grant/rvalid bus between the Ibex fetch/LSU ports, the arbiter and the DFFRAM port.
// master = core/RAM environment side, slave = arbiter side.
interface ibex_dffram_arbiter_if #(
  parameter int unsigned ADDR_W = 12
);
  logic              instr_req_i;
  logic [31:0]       instr_addr_i;
  logic              instr_gnt_o;
  logic              instr_rvalid_o;
  logic [31:0]       instr_rdata_o;
  logic              instr_err_o;

  logic              data_req_i;
  logic              data_we_i;
  logic [3:0]        data_be_i;
  logic [31:0]       data_addr_i;
  logic [31:0]       data_wdata_i;
  logic              data_gnt_o;
  logic              data_rvalid_o;
  logic [31:0]       data_rdata_o;
  logic              data_err_o;

  logic              ram_en_o;
  logic [3:0]        ram_we_o;
  logic [ADDR_W-1:0] ram_a_o;
  logic [31:0]       ram_di_o;
  logic [31:0]       ram_do_i;

  modport master (
    output instr_req_i, instr_addr_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
    input  ram_en_o, ram_we_o, ram_a_o, ram_di_o,
    output ram_do_i
  );

  modport slave (
    input  instr_req_i, instr_addr_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
    output ram_en_o, ram_we_o, ram_a_o, ram_di_o,
    input  ram_do_i
  );
endinterface

// File: rtl/ibex_dffram_arbiter.sv
// Two-requester arbiter in front of a single-port DFFRAM: data-first priority with a
// fetch anti-starvation override, window decode and a one-cycle registered response.
module ibex_dffram_arbiter #(
  parameter int unsigned ADDR_W    = 12,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WAIT  = 4
) (
  input logic clk_i,
  input logic rst_ni,
  ibex_dffram_arbiter_if.slave bus
);
  localparam int unsigned HI       = ADDR_W + 2;
  localparam logic [3:0]  WAIT_LIM = 4'(MAX_WAIT);

  logic       instr_req, data_req;
  logic       instr_in, data_in;
  logic       instr_win, data_win, any_win;
  logic [3:0] wait_cnt;
  logic       resp_valid, resp_owner, resp_err, resp_rd;

  // Requests are masked while in reset so every output reads 0 during reset.
  assign instr_req = bus.instr_req_i & rst_ni;
  assign data_req  = bus.data_req_i  & rst_ni;

  assign instr_in = (bus.instr_addr_i[31:HI] == BASE_ADDR[31:HI]);
  assign data_in  = (bus.data_addr_i[31:HI]  == BASE_ADDR[31:HI]);

  assign instr_win = instr_req & (~data_req | (wait_cnt == WAIT_LIM));
  assign data_win  = data_req & ~instr_win;
  assign any_win   = instr_win | data_win;

  assign bus.instr_gnt_o = instr_win;
  assign bus.data_gnt_o  = data_win;

  assign bus.ram_en_o = (instr_win & instr_in) | (data_win & data_in);
  assign bus.ram_we_o = (data_win & bus.data_we_i & data_in) ? bus.data_be_i : 4'b0;
  assign bus.ram_di_o = rst_ni ? bus.data_wdata_i : 32'h0;
  assign bus.ram_a_o  = !rst_ni   ? '0 :
                        instr_win ? bus.instr_addr_i[HI-1:2] : bus.data_addr_i[HI-1:2];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_cnt   <= 4'd0;
      resp_valid <= 1'b0;
      resp_owner <= 1'b0;
      resp_err   <= 1'b0;
      resp_rd    <= 1'b0;
    end else begin
      if (!instr_req || instr_win)  wait_cnt <= 4'd0;
      else if (wait_cnt != WAIT_LIM) wait_cnt <= wait_cnt + 4'd1;

      // Overwriting while the previous response is presented is safe: rvalid never stalls.
      resp_valid <= any_win;
      resp_owner <= data_win;
      resp_err   <= instr_win ? ~instr_in : ~data_in;
      resp_rd    <= instr_win ? instr_in : (data_in & ~bus.data_we_i);
    end
  end

  assign bus.instr_rvalid_o = resp_valid & ~resp_owner;
  assign bus.data_rvalid_o  = resp_valid &  resp_owner;
  assign bus.instr_err_o    = bus.instr_rvalid_o & resp_err;
  assign bus.data_err_o     = bus.data_rvalid_o  & resp_err;
  // Gating on the owner's rvalid keeps stale RAM output off the other port.
  assign bus.instr_rdata_o  = (bus.instr_rvalid_o & resp_rd) ? bus.ram_do_i : 32'h0;
  assign bus.data_rdata_o   = (bus.data_rvalid_o  & resp_rd) ? bus.ram_do_i : 32'h0;
endmodule

// File: tb/tb_ibex_dffram_arbiter.sv
// Random + directed bench for ibex_dffram_arbiter against a transaction-level model
// (grant choice, window check, word memory and one pending response per cycle).
module tb_ibex_dffram_arbiter;
  localparam int unsigned ADDR_W   = 12;
  localparam logic [31:0] BASE     = 32'h0000_0000;
  localparam int unsigned MAX_WAIT = 4;
  localparam int unsigned WIN      = 1 << (ADDR_W + 2);
  localparam int unsigned WORDS    = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  ibex_dffram_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  ibex_dffram_arbiter #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .MAX_WAIT(MAX_WAIT)) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus)
  );

  function automatic logic [31:0] init_val(input int unsigned i);
    case (i)
      0:       return 32'h0000_0013;
      1:       return 32'h1111_1111;
      2:       return 32'hAABB_CCDD;
      4:       return 32'hDEAD_BEEF;
      default: return i * 32'h9E37_79B1;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // RAM environment: synchronous read, byte-masked write, data valid the cycle after enable.
  logic [31:0] ram_mem [WORDS];
  logic        ram_ready = 1'b0;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < int'(WORDS); i++) ram_mem[i] <= init_val(i);
      ram_ready <= 1'b1;
    end else if (bus.ram_en_o) begin
      bus.ram_do_i <= ram_mem[bus.ram_a_o];
      for (int b = 0; b < 4; b++)
        if (bus.ram_we_o[b]) ram_mem[bus.ram_a_o][8*b +: 8] <= bus.ram_di_o[8*b +: 8];
    end
  end
  initial bus.ram_do_i = 32'h0;

  // Reference model: evaluated mid-cycle once inputs are stable, then advanced one cycle.
  logic [31:0] ref_mem [WORDS];
  bit          ref_ready = 0;
  int          waited = 0;
  bit          p_v = 0, p_data = 0, p_err = 0;
  logic [31:0] p_rdata = 32'h0;

  always @(negedge clk) begin
    bit ir, dr, dw, iin, din, iwin, dwin, ren;
    int unsigned iw, dword;
    logic [3:0]  rwe;
    logic [11:0] ra;
    logic [31:0] rdi;
    if (!ref_ready) begin
      for (int i = 0; i < int'(WORDS); i++) ref_mem[i] = init_val(i);
      ref_ready = 1;
    end
    ir  = rst_n && bus.instr_req_i;
    dr  = rst_n && bus.data_req_i;
    dw  = bus.data_we_i;
    iin = (bus.instr_addr_i / WIN) == (BASE / WIN);
    din = (bus.data_addr_i  / WIN) == (BASE / WIN);
    iw    = (bus.instr_addr_i % WIN) / 4;
    dword = (bus.data_addr_i  % WIN) / 4;
    iwin = ir && (!dr || waited >= int'(MAX_WAIT));
    dwin = dr && !iwin;
    if (!rst_n) begin
      p_v = 0; waited = 0;
    end
    ren = (iwin && iin) || (dwin && din);
    rwe = (dwin && dw && din) ? bus.data_be_i : 4'h0;
    ra  = !rst_n ? 12'h0 : (iwin ? iw[11:0] : dword[11:0]);
    rdi = rst_n ? bus.data_wdata_i : 32'h0;

    chk("instr_gnt", {31'h0, bus.instr_gnt_o}, {31'h0, iwin});
    chk("data_gnt",  {31'h0, bus.data_gnt_o},  {31'h0, dwin});
    chk("ram_en",    {31'h0, bus.ram_en_o},    {31'h0, ren});
    chk("ram_we",    {28'h0, bus.ram_we_o},    {28'h0, rwe});
    chk("ram_a",     {20'h0, bus.ram_a_o},     {20'h0, ra});
    chk("ram_di",    bus.ram_di_o,             rdi);
    chk("instr_rvalid", {31'h0, bus.instr_rvalid_o}, {31'h0, p_v && !p_data});
    chk("instr_err",    {31'h0, bus.instr_err_o},    {31'h0, p_v && !p_data && p_err});
    chk("instr_rdata",  bus.instr_rdata_o, (p_v && !p_data) ? p_rdata : 32'h0);
    chk("data_rvalid",  {31'h0, bus.data_rvalid_o},  {31'h0, p_v && p_data});
    chk("data_err",     {31'h0, bus.data_err_o},     {31'h0, p_v && p_data && p_err});
    chk("data_rdata",   bus.data_rdata_o,  (p_v && p_data) ? p_rdata : 32'h0);

    if (rst_n) begin
      p_v = iwin || dwin;
      if (iwin) begin
        p_data = 0; p_err = !iin; p_rdata = iin ? ref_mem[iw] : 32'h0;
      end else if (dwin) begin
        p_data = 1; p_err = !din; p_rdata = (din && !dw) ? ref_mem[dword] : 32'h0;
        if (din && dw)
          for (int b = 0; b < 4; b++)
            if (bus.data_be_i[b]) ref_mem[dword][8*b +: 8] = bus.data_wdata_i[8*b +: 8];
      end
      if (!ir || iwin) waited = 0;
      else if (waited < int'(MAX_WAIT)) waited++;
    end
  end

  task automatic drive(input bit ir, input logic [31:0] ia, input bit dr, input bit dw,
                       input logic [3:0] be, input logic [31:0] da, input logic [31:0] wd);
    @(posedge clk); #1;
    bus.instr_req_i = ir; bus.instr_addr_i = ia;
    bus.data_req_i = dr; bus.data_we_i = dw; bus.data_be_i = be;
    bus.data_addr_i = da; bus.data_wdata_i = wd;
    @(negedge clk); #1;
  endtask

  task automatic idle();
    drive(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin
    bus.instr_req_i = 0; bus.instr_addr_i = 0; bus.data_req_i = 0; bus.data_we_i = 0;
    bus.data_be_i = 0; bus.data_addr_i = 0; bus.data_wdata_i = 0;

    // Requests held during reset must not be granted.
    drive(1, 32'h4, 1, 1, 4'hF, 32'h10, 32'hFFFF_FFFF);
    chk("rst_instr_gnt", {31'h0, bus.instr_gnt_o}, 32'h0);
    chk("rst_ram_en",    {31'h0, bus.ram_en_o},    32'h0);
    idle();
    @(posedge clk); #1; rst_n = 1'b1;
    idle();

    // Plain data read of word 4.
    drive(0, 32'h0, 1, 0, 4'hF, 32'h0000_0010, 32'h0);
    chk("rd_gnt",   {31'h0, bus.data_gnt_o}, 32'h1);
    chk("rd_ram_a", {20'h0, bus.ram_a_o},    32'h4);
    chk("rd_ram_en", {31'h0, bus.ram_en_o},  32'h1);
    idle();
    chk("rd_rvalid", {31'h0, bus.data_rvalid_o}, 32'h1);
    chk("rd_rdata",  bus.data_rdata_o, 32'hDEAD_BEEF);

    // Partial write then read-back of word 2.
    drive(0, 32'h0, 1, 1, 4'b0101, 32'h8, 32'h1122_3344);
    chk("wr_ram_we", {28'h0, bus.ram_we_o}, 32'h5);
    drive(0, 32'h0, 1, 0, 4'hF, 32'h8, 32'h0);
    chk("wr_rvalid", {31'h0, bus.data_rvalid_o}, 32'h1);
    chk("wr_rdata",  bus.data_rdata_o, 32'h0);
    idle();
    chk("rmw_rdata", bus.data_rdata_o, 32'hAA22_CC44);

    // Both requesting continuously: fetch wins every fifth cycle.
    for (int c = 0; c < 10; c++) begin
      drive(1, 32'h20, 1, 0, 4'hF, 32'h10, 32'h0);
      chk("starve_instr_gnt", {31'h0, bus.instr_gnt_o}, {31'h0, (c % 5) == 4});
    end
    idle();

    // Out-of-window fetch.
    drive(1, 32'h0001_0000, 0, 0, 4'h0, 32'h0, 32'h0);
    chk("oow_gnt",    {31'h0, bus.instr_gnt_o}, 32'h1);
    chk("oow_ram_en", {31'h0, bus.ram_en_o},    32'h0);
    idle();
    chk("oow_err",   {31'h0, bus.instr_err_o}, 32'h1);
    chk("oow_rdata", bus.instr_rdata_o, 32'h0);

    // Back-to-back fetches.
    drive(1, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    drive(1, 32'h4, 0, 0, 4'h0, 32'h0, 32'h0);
    chk("b2b_w0", bus.instr_rdata_o, 32'h0000_0013);
    drive(1, 32'h8, 0, 0, 4'h0, 32'h0, 32'h0);
    chk("b2b_w1", bus.instr_rdata_o, 32'h1111_1111);
    idle();
    chk("b2b_w2", bus.instr_rdata_o, 32'hAA22_CC44);

    // Reset right after a data grant drops the response.
    drive(0, 32'h0, 1, 0, 4'hF, 32'h10, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b0; bus.data_req_i = 0;
    @(negedge clk); #1;
    chk("mid_rst_rvalid", {31'h0, bus.data_rvalid_o}, 32'h0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk); #1;
    chk("post_rst_rvalid", {31'h0, bus.data_rvalid_o}, 32'h0);
    drive(0, 32'h0, 1, 0, 4'hF, 32'h10, 32'h0);
    idle();
    chk("post_rst_rdata", bus.data_rdata_o, 32'hDEAD_BEEF);

    // Randomized traffic, with occasional one-cycle resets.
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] ia, da;
      ia = {$urandom_range(0, 31), 2'(($urandom_range(0, 3)))};
      da = {$urandom_range(0, 31), 2'(($urandom_range(0, 3)))};
      if ($urandom_range(0, 9) == 0) ia = ia | 32'h0001_0000 << $urandom_range(0, 15);
      if ($urandom_range(0, 9) == 0) da = da | 32'h0000_4000 << $urandom_range(0, 17);
      if ($urandom_range(0, 299) == 0) begin
        @(posedge clk); #1; rst_n = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
      end
      drive($urandom_range(0, 9) < 6, ia, $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 4,
            4'($urandom), da, $urandom);
    end
    idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ibex_dffram_arbiter.md
Name: ibex_dffram_arbiter

Overview:
- Sits directly upstream of the single-port 4K x 32 DFFRAM.
- Arbitrates the Ibex instruction-fetch and LSU request/grant/rvalid interfaces onto the one RAM port.
- Data port has fixed priority, with an anti-starvation override for instruction fetch.
- Decodes the address window, returns rvalid one cycle after grant, and flags out-of-window accesses as bus errors.

Parameters:
- ADDR_W, 12, RAM word-address width; window covers 2**(ADDR_W+2) bytes.
- BASE_ADDR, 32'h0000_0000, byte base of RAM window; must be aligned to the window size.
- MAX_WAIT, 4, consecutive stalled instr-request cycles before instr gets priority; range 1..15.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset
- instr_req_i  in  1  fetch request
- instr_addr_i  in  32  fetch byte address
- instr_gnt_o  out  1  fetch grant
- instr_rvalid_o  out  1  fetch response valid
- instr_rdata_o  out  32  fetch read data
- instr_err_o  out  1  fetch bus error
- data_req_i  in  1  LSU request
- data_we_i  in  1  LSU write
- data_be_i  in  4  LSU byte enables
- data_addr_i  in  32  LSU byte address
- data_wdata_i  in  32  LSU write data
- data_gnt_o  out  1  LSU grant
- data_rvalid_o  out  1  LSU response valid
- data_rdata_o  out  32  LSU read data
- data_err_o  out  1  LSU bus error
- ram_en_o  out  1  RAM chip enable
- ram_we_o  out  4  RAM byte write mask
- ram_a_o  out  ADDR_W  RAM word address
- ram_di_o  out  32  RAM write data
- ram_do_i  in  32  RAM read data; valid the cycle after ram_en_o

Behaviour:
- Clock and reset: one clock, clk_i; rst_ni is asynchronous, active-low.
- Reset values: all registered state cleared; every output is 0 during and immediately after reset.
- Reset mid-operation: any pending response is dropped, with no rvalid after release.
- Grant timing:
  - Grant is combinational, in the same cycle as the request.
  - At most one gnt is high per cycle.
  - A granted request completes in exactly one cycle.
  - No outstanding-request limit beyond one per cycle; back-to-back grants are allowed.
- Arbitration:
  - Only one requester: it is granted.
  - Both requesting: data wins, unless wait_cnt == MAX_WAIT, in which case instr wins.
- wait_cnt (4-bit):
  - Increments each cycle instr_req_i=1 and instr_gnt_o=0, saturating at MAX_WAIT.
  - Cleared on instr grant or when instr_req_i=0.
- Address decode:
  - in_range = (addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]).
  - ram_a_o = addr[ADDR_W+1:2]; addr[1:0] is ignored.
- RAM drive (combinational from the granted request):
  - ram_en_o = grant & in_range.
  - ram_we_o = data_be_i when data granted & data_we_i & in_range, else 4'b0.
  - ram_di_o = data_wdata_i.
  - ram_a_o muxed from the winner; it follows the data address when nothing is granted.
  - Instruction fetches never write.
- Response register, loaded on any grant:
  - resp_valid, resp_owner (0=instr, 1=data), resp_err = !in_range, resp_rd = in_range & !write.
  - Cycle N+1 after grant: the owner's rvalid_o=1 for exactly one cycle.
  - Owner's err_o = resp_err.
  - Owner's rdata_o = ram_do_i if resp_rd, else 32'h0.
- Non-owner outputs: rdata_o and err_o are 0 whenever that port's rvalid_o is 0. Stale ram_do_i must never leak.
- Out-of-window access: granted, no RAM enable, err response next cycle with rdata 0.
- Simultaneous grant and response: a new grant in cycle N+1 overwrites the response register while the cycle-N response is being presented. This is legal because rvalid is never stalled.

Test Plan:
- Data read only, addr 32'h0000_0010, RAM word 4 = 32'hDEADBEEF -> data_gnt_o same cycle, ram_a_o=4, ram_en_o=1, ram_we_o=0; next cycle data_rvalid_o=1, data_rdata_o=32'hDEADBEEF, data_err_o=0.
- Data write addr 32'h8, be=4'b0101, wdata=32'h11223344, then read addr 8 -> ram_we_o=4'b0101 on write, write rvalid with rdata 0; read returns 32'hxx22xx44 bytes updated, other bytes preserved.
- instr_req and data_req both held high continuously -> data granted cycles 0-3; cycle 4 instr granted (wait_cnt=4); pattern repeats 4:1; each rvalid goes to the correct owner with no cross-leak of rdata.
- instr addr 32'h0001_0000 with BASE=0, ADDR_W=12 -> instr_gnt_o=1, ram_en_o=0; next cycle instr_rvalid_o=1, instr_err_o=1, instr_rdata_o=0.
- Back-to-back instr fetches 0x0, 0x4, 0x8 on consecutive cycles -> three consecutive rvalid cycles with the matching words, one-cycle latency each.
- Assert rst_ni low the cycle after a data grant -> no data_rvalid_o ever appears; all outputs 0 during reset; first post-reset request behaves normally.
